// File: rtl/sram_port_arbiter.sv
module sram_port_arbiter #(
  parameter int unsigned OUTST_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PW = $clog2(OUTST_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OUTST_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]          cnt;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [OUTST_DEPTH-1:0] owner_q;

  logic grant, owner, can_issue, empty, head, push, pop;

  assign can_issue = (cnt < DEPTH_C);
  assign empty     = (cnt == '0);
  assign head      = owner_q[rd_ptr];

  // Grant selection and next state; everything is gated off while reset is high.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    owner     = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (can_issue) begin
            if (data_req) begin
              grant = 1'b1;
              owner = 1'b1;
              if (!mem_addr_ok) state_nxt = HOLD_D;
            end else if (inst_req) begin
              grant = 1'b1;
              if (!mem_addr_ok) state_nxt = HOLD_I;
            end
          end
        end
        HOLD_I: begin
          grant = 1'b1;
          if (mem_addr_ok) state_nxt = IDLE;
        end
        HOLD_D: begin
          grant = 1'b1;
          owner = 1'b1;
          if (mem_addr_ok) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req   = grant;
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant) begin
      if (owner) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_wstrb = inst_wstrb;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
    end
  end

  assign push = grant & mem_addr_ok;
  assign pop  = !reset & mem_data_ok & !empty;

  assign inst_addr_ok = push & !owner;
  assign data_addr_ok = push & owner;
  assign inst_data_ok = pop & !head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) owner_q[wr_ptr] <= owner;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  logic        clk, reset;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic        sb[$];

  sram_port_arbiter #(.OUTST_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic req, input logic [31:0] addr);
    inst_req   = req;
    inst_wr    = 1'b0;
    inst_size  = 2'd2;
    inst_wstrb = 4'h0;
    inst_addr  = addr;
    inst_wdata = 32'h0;
  endtask

  task automatic set_data(input logic req, input logic wr, input logic [31:0] addr,
                          input logic [3:0] wstrb, input logic [31:0] wdata);
    data_req   = req;
    data_wr    = wr;
    data_size  = 2'd2;
    data_wstrb = wstrb;
    data_addr  = addr;
    data_wdata = wdata;
  endtask

  // Checks one cycle at the falling edge; expected owners come from the scoreboard.
  task automatic look(input string tag, input logic exp_req, input logic exp_own,
                      input logic [31:0] exp_addr);
    logic own;
    @(negedge clk);
    check({tag, ":mem_req"}, 32'(mem_req), 32'(exp_req));
    if (exp_req) begin
      check({tag, ":mem_addr"}, mem_addr, exp_addr);
      check({tag, ":inst_addr_ok"}, 32'(inst_addr_ok), 32'(mem_addr_ok & !exp_own));
      check({tag, ":data_addr_ok"}, 32'(data_addr_ok), 32'(mem_addr_ok & exp_own));
      if (mem_addr_ok) sb.push_back(exp_own);
    end else begin
      check({tag, ":mem_addr_idle"}, mem_addr, 32'h0);
      check({tag, ":addr_ok_idle"}, {30'h0, inst_addr_ok, data_addr_ok}, 32'h0);
    end
    if (mem_data_ok) begin
      if (sb.size() > 0) begin
        own = sb.pop_front();
        check({tag, ":data_data_ok"}, 32'(data_data_ok), 32'(own));
        check({tag, ":inst_data_ok"}, 32'(inst_data_ok), 32'(!own));
      end else begin
        check({tag, ":stray_resp"}, {30'h0, inst_data_ok, data_data_ok}, 32'h0);
      end
    end else begin
      check({tag, ":no_resp"}, {30'h0, inst_data_ok, data_data_ok}, 32'h0);
    end
    check({tag, ":rdata"}, inst_rdata ^ data_rdata ^ mem_rdata, mem_rdata);
  endtask

  task automatic cyc(input string tag, input logic exp_req, input logic exp_own,
                     input logic [31:0] exp_addr);
    look(tag, exp_req, exp_own, exp_addr);
    adv();
  endtask

  task automatic quiet();
    set_inst(1'b0, 32'h0);
    set_data(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
  endtask

  task automatic drain(input string tag, input int unsigned n);
    quiet();
    mem_data_ok = 1'b1;
    for (int unsigned k = 0; k < n; k++) begin
      mem_rdata = 32'hD000_0000 + k;
      cyc(tag, 1'b0, 1'b0, 32'h0);
    end
    mem_data_ok = 1'b0;
  endtask

  initial begin
    quiet();
    mem_rdata = 32'hA5A5_5A5A;

    // Reset with every input active: outputs gated, rdata still mirrors.
    reset = 1'b1;
    set_inst(1'b1, 32'h1C00_0000);
    set_data(1'b1, 1'b1, 32'h100, 4'hF, 32'h1234);
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    @(negedge clk);
    check("rst:mem_req", 32'(mem_req), 32'h0);
    check("rst:mem_addr", mem_addr, 32'h0);
    check("rst:mem_wdata", mem_wdata, 32'h0);
    check("rst:oks", {28'h0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'h0);
    check("rst:rdata", inst_rdata, 32'hA5A5_5A5A);
    adv();
    adv();
    reset = 1'b0;
    quiet();
    check("rst:cnt", 32'(dut.cnt), 32'h0);

    // Solo fetch
    set_inst(1'b1, 32'h1C00_0000);
    mem_addr_ok = 1'b1;
    cyc("solo_req", 1'b1, 1'b0, 32'h1C00_0000);
    quiet();
    cyc("solo_gap", 1'b0, 1'b0, 32'h0);
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0280_0C0C;
    cyc("solo_resp", 1'b0, 1'b0, 32'h0);

    // Simultaneous: data first, then inst
    quiet();
    set_inst(1'b1, 32'h1C00_0004);
    set_data(1'b1, 1'b1, 32'h100, 4'b0011, 32'hBEEF);
    mem_addr_ok = 1'b1;
    look("sim_d", 1'b1, 1'b1, 32'h100);
    check("sim_d:wr", 32'(mem_wr), 32'h1);
    check("sim_d:wstrb", 32'(mem_wstrb), 32'h3);
    check("sim_d:wdata", mem_wdata, 32'hBEEF);
    adv();
    set_data(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    look("sim_i", 1'b1, 1'b0, 32'h1C00_0004);
    check("sim_i:wr", 32'(mem_wr), 32'h0);
    adv();
    drain("sim_resp", 2);

    // Hold lock: data arrives during an inst hold and must wait
    quiet();
    set_inst(1'b1, 32'h1C00_0008);
    cyc("hold_c1", 1'b1, 1'b0, 32'h1C00_0008);
    set_data(1'b1, 1'b0, 32'h200, 4'h0, 32'h0);
    cyc("hold_c2", 1'b1, 1'b0, 32'h1C00_0008);
    cyc("hold_c3", 1'b1, 1'b0, 32'h1C00_0008);
    mem_addr_ok = 1'b1;
    cyc("hold_acc", 1'b1, 1'b0, 32'h1C00_0008);
    set_inst(1'b0, 32'h0);
    cyc("hold_data", 1'b1, 1'b1, 32'h200);
    drain("hold_resp", 2);

    // Full: four accepted, fifth blocked until a pop has been registered
    quiet();
    mem_addr_ok = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      set_data(1'b1, 1'b0, 32'h1000 + 4 * i, 4'h0, 32'h0);
      cyc("full_fill", 1'b1, 1'b1, 32'h1000 + 4 * i);
    end
    set_data(1'b1, 1'b0, 32'h2000, 4'h0, 32'h0);
    cyc("full_block", 1'b0, 1'b0, 32'h0);
    mem_data_ok = 1'b1;
    cyc("full_pop_block", 1'b0, 1'b0, 32'h0);
    mem_data_ok = 1'b0;
    cyc("full_issue", 1'b1, 1'b1, 32'h2000);
    drain("full_resp", 4);

    // Push and pop together at cnt=2, across pointer wrap
    quiet();
    mem_addr_ok = 1'b1;
    set_inst(1'b1, 32'h3000);
    cyc("pp_pre_i", 1'b1, 1'b0, 32'h3000);
    set_inst(1'b0, 32'h0);
    set_data(1'b1, 1'b0, 32'h3004, 4'h0, 32'h0);
    cyc("pp_pre_d", 1'b1, 1'b1, 32'h3004);
    mem_data_ok = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      if ((i % 3) == 1) begin
        set_data(1'b1, 1'b0, 32'h4000 + 4 * i, 4'h0, 32'h0);
        set_inst(1'b0, 32'h0);
      end else begin
        set_data(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_inst(1'b1, 32'h4000 + 4 * i);
      end
      mem_rdata = 32'hC000_0000 + i;
      cyc("pp_loop", 1'b1, (i % 3) == 1, 32'h4000 + 4 * i);
      check("pp_cnt", 32'(dut.cnt), 32'h2);
    end
    drain("pp_drain", 3);
    check("pp_empty", 32'(dut.cnt), 32'h0);

    // Mid-operation reset with three outstanding
    quiet();
    mem_addr_ok = 1'b1;
    set_inst(1'b1, 32'h5000);
    cyc("mr_a", 1'b1, 1'b0, 32'h5000);
    set_inst(1'b0, 32'h0);
    set_data(1'b1, 1'b0, 32'h5004, 4'h0, 32'h0);
    cyc("mr_b", 1'b1, 1'b1, 32'h5004);
    set_data(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_inst(1'b1, 32'h5008);
    cyc("mr_c", 1'b1, 1'b0, 32'h5008);
    quiet();
    reset = 1'b1;
    mem_data_ok = 1'b1;
    @(negedge clk);
    check("mr_rst:oks", {28'h0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'h0);
    adv();
    reset = 1'b0;
    sb.delete();
    check("mr_cnt", 32'(dut.cnt), 32'h0);
    check("mr_state", 32'(dut.state), 32'h0);
    cyc("mr_stray", 1'b0, 1'b0, 32'h0);
    quiet();
    cyc("mr_quiet", 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
